// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the pipeline registers it steers.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  // addi x0, x0, 0 -- the bubble loaded by any *_flush
  localparam logic [63:0] NOP_INSN = 64'h13;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running wrap-around event counter with synchronous clear.
module hazard_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, dmem freeze, imem miss and redirect drain,
// plus stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_mem_read,
  input  logic             EX_redirect,
  input  logic             MEM_mem_access,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] LU_INIT = 2'(LOAD_USE_STALL - 1);

  hz_state_t  state, state_nxt;
  logic [1:0] lu_cnt, lu_cnt_nxt;
  pipe_ctrl_t ctrl;
  logic       freeze, lu, redirect_acc;

  assign freeze = MEM_mem_access & ~dmem_ready;
  assign lu     = EX_mem_read & (EX_rd != 5'd0) &
                  ((ID_use_rs1 & (EX_rd == ID_rs1)) | (ID_use_rs2 & (EX_rd == ID_rs2)));

  always_comb begin
    ctrl         = '0;
    state_nxt    = state;
    lu_cnt_nxt   = lu_cnt;
    redirect_acc = 1'b0;
    if (!rstn) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
      state_nxt         = RUN;
      lu_cnt_nxt        = '0;
    end else if (freeze) begin
      // Whole pipe holds; MEM/WB gets a bubble while the access is outstanding.
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (EX_redirect) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      redirect_acc     = 1'b1;
      state_nxt        = imem_ready ? RUN : DRAIN;
      lu_cnt_nxt       = '0;
    end else if (state == DRAIN) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_flush = 1'b1;
      if (imem_ready)
        state_nxt = RUN;
    end else if ((state == RUN && lu) || state == LU_STALL) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_stall = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      if (state == RUN) begin
        if (LOAD_USE_STALL > 1) begin
          state_nxt  = LU_STALL;
          lu_cnt_nxt = LU_INIT;
        end
      end else begin
        if (lu_cnt == 2'd1)
          state_nxt = RUN;
        lu_cnt_nxt = lu_cnt - 2'd1;
      end
    end else if (state == RUN && !imem_ready) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (~rstn),
    .en    (rstn & ctrl.pc_stall),
    .count (stall_cycles)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (~rstn),
    .en    (rstn & redirect_acc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two controllers (1-cycle and 2-cycle load-use, the latter with 4-bit counters) on shared stimulus.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic       ID_use_rs1, ID_use_rs2, EX_mem_read, EX_redirect;
  logic       MEM_mem_access, dmem_ready, imem_ready;

  logic        a_pc_s, a_ifid_s, a_ifid_f, a_idex_s, a_idex_f, a_exmem_s, a_memwb_f;
  logic        b_pc_s, b_ifid_s, b_ifid_f, b_idex_s, b_idex_f, b_exmem_s, b_memwb_f;
  logic [63:0] a_stall, a_flush;
  logic [3:0]  b_stall, b_flush;
  logic [6:0]  ctrl_a, ctrl_b;

  assign ctrl_a = {a_pc_s, a_ifid_s, a_ifid_f, a_idex_s, a_idex_f, a_exmem_s, a_memwb_f};
  assign ctrl_b = {b_pc_s, b_ifid_s, b_ifid_f, b_idex_s, b_idex_f, b_exmem_s, b_memwb_f};

  // {pc_s, if_id_s, if_id_f, id_ex_s, id_ex_f, ex_mem_s, mem_wb_f}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_FRZ  = 7'b1101011;
  localparam logic [6:0] C_RDR  = 7'b0010100;
  localparam logic [6:0] C_DRN  = 7'b1010000;
  localparam logic [6:0] C_RST  = 7'b0010101;

  hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(64)) u_a (
    .clk(clk), .rstn(rstn), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1),
    .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd), .EX_mem_read(EX_mem_read), .EX_redirect(EX_redirect),
    .MEM_mem_access(MEM_mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_stall(a_pc_s), .if_id_stall(a_ifid_s), .if_id_flush(a_ifid_f), .id_ex_stall(a_idex_s),
    .id_ex_flush(a_idex_f), .ex_mem_stall(a_exmem_s), .mem_wb_flush(a_memwb_f),
    .stall_cycles(a_stall), .flush_events(a_flush));

  hazard_ctrl #(.LOAD_USE_STALL(2), .CNT_W(4)) u_b (
    .clk(clk), .rstn(rstn), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1),
    .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd), .EX_mem_read(EX_mem_read), .EX_redirect(EX_redirect),
    .MEM_mem_access(MEM_mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_stall(b_pc_s), .if_id_stall(b_ifid_s), .if_id_flush(b_ifid_f), .id_ex_stall(b_idex_s),
    .id_ex_flush(b_idex_f), .ex_mem_stall(b_exmem_s), .mem_wb_flush(b_memwb_f),
    .stall_cycles(b_stall), .flush_events(b_flush));

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [6:0] exp_a, input logic [6:0] exp_b);
    check({tag, ".a"}, 64'(ctrl_a), 64'(exp_a));
    check({tag, ".b"}, 64'(ctrl_b), 64'(exp_b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    EX_rd = 5'd0; EX_mem_read = 1'b0; EX_redirect = 1'b0;
    MEM_mem_access = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  task automatic set_lu();
    EX_mem_read = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    // reset values
    idle();
    rstn = 1'b0;
    #1;
    ctl("rst_out", C_RST, C_RST);
    tick();
    rstn = 1'b1;
    #1;
    ctl("idle", C_NONE, C_NONE);
    check("rst_stall.a", a_stall, 64'd0);
    check("rst_flush.a", a_flush, 64'd0);

    // 1/2: load-use on rs1, 1 vs 2 bubbles
    set_lu();
    #1 ctl("lu_c1", C_LU, C_LU);
    tick();
    EX_mem_read = 1'b0;
    #1 ctl("lu_c2", C_NONE, C_LU);
    tick();
    #1 ctl("lu_c3", C_NONE, C_NONE);
    check("lu_stall.a", a_stall, 64'd1);
    check("lu_stall.b", 64'(b_stall), 64'd2);

    // load into x0 and unused operand: no hazard; rs2 match: hazard
    EX_mem_read = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
    #1 ctl("lu_x0", C_NONE, C_NONE);
    EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 1'b0;
    #1 ctl("lu_nouse", C_NONE, C_NONE);
    ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
    #1 ctl("lu_rs2", C_LU, C_LU);

    // 3: freeze with pending load-use, then the bubble; freeze also holds LU_STALL count
    do_reset();
    MEM_mem_access = 1'b1; dmem_ready = 1'b0; set_lu();
    for (int unsigned i = 0; i < 3; i++) begin
      #1 ctl("frz", C_FRZ, C_FRZ);
      tick();
    end
    dmem_ready = 1'b1;
    #1 ctl("frz_lu", C_LU, C_LU);
    tick();
    check("frz_stall.a", a_stall, 64'd4);
    MEM_mem_access = 1'b1; dmem_ready = 1'b0; EX_mem_read = 1'b0;
    #1 ctl("frz_in_lus", C_FRZ, C_FRZ);
    tick();
    MEM_mem_access = 1'b0; dmem_ready = 1'b1;
    #1 ctl("lus_after_frz", C_NONE, C_LU);
    tick();
    #1 ctl("lus_done", C_NONE, C_NONE);
    check("frz_stall.b", 64'(b_stall), 64'd6);

    // 4: redirect with imem miss, drain through the stale response
    do_reset();
    EX_redirect = 1'b1; imem_ready = 1'b0;
    #1 ctl("rdr", C_RDR, C_RDR);
    tick();
    EX_redirect = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      #1 ctl("drain", C_DRN, C_DRN);
      tick();
    end
    imem_ready = 1'b1;
    #1 ctl("drain_last", C_DRN, C_DRN);
    tick();
    #1 ctl("drain_exit", C_NONE, C_NONE);
    check("drn_flush.a", a_flush, 64'd1);
    check("drn_stall.a", a_stall, 64'd3);

    // 5: redirect beats load-use and fetch miss; cancels LU_STALL; ignored during freeze
    do_reset();
    EX_redirect = 1'b1; imem_ready = 1'b0; set_lu();
    #1 ctl("rdr_prio", C_RDR, C_RDR);
    tick();
    idle();
    #1 ctl("rdr_drain", C_DRN, C_DRN);
    tick();
    set_lu();
    #1 ctl("lu_again", C_LU, C_LU);
    tick();
    idle();
    EX_redirect = 1'b1;
    #1 ctl("rdr_cancel", C_RDR, C_RDR);
    tick();
    EX_redirect = 1'b0;
    #1 ctl("rdr_cancel_run", C_NONE, C_NONE);
    EX_redirect = 1'b1; MEM_mem_access = 1'b1; dmem_ready = 1'b0;
    #1 ctl("rdr_frz", C_FRZ, C_FRZ);
    tick();
    check("rdr_frz_flush.a", a_flush, 64'd2);
    dmem_ready = 1'b1;
    #1 ctl("rdr_after_frz", C_RDR, C_RDR);
    tick();
    check("rdr_flush.a", a_flush, 64'd3);
    check("rdr_flush.b", 64'(b_flush), 64'd3);

    // 6: reset while draining
    do_reset();
    EX_redirect = 1'b1; imem_ready = 1'b0;
    tick();
    EX_redirect = 1'b0;
    #1 ctl("pre_rst_drain", C_DRN, C_DRN);
    rstn = 1'b0;
    #1 ctl("rst_in_drain", C_RST, C_RST);
    tick();
    rstn = 1'b1; imem_ready = 1'b1;
    #1 ctl("post_rst_run", C_NONE, C_NONE);
    check("post_rst_stall.a", a_stall, 64'd0);
    check("post_rst_flush.a", a_flush, 64'd0);

    // counter wrap: 17 fetch-miss cycles into a 4-bit counter
    imem_ready = 1'b0;
    #1 ctl("miss", C_DRN, C_DRN);
    for (int unsigned i = 0; i < 17; i++) tick();
    check("wrap_stall.a", a_stall, 64'd17);
    check("wrap_stall.b", 64'(b_stall), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
